// File: rtl/canny_pkg.sv
`default_nettype none
// ============================================================================
// Module   : canny_pkg
// Brief    : Shared widths, direction codes and helpers for the Canny
//            gradient stage.
// Revision : 1.0 - initial release
// ============================================================================
package canny_pkg;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W  = 12;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } grad_dir_t;

    // Weighted column/row sum a + 2b + c; the result never exceeds 4*255.
    function automatic logic [PIX_W+1:0] wsum(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
        return (PIX_W+2)'(a) + (PIX_W+2)'({b, 1'b0}) + (PIX_W+2)'(c);
    endfunction

    // Magnitude of a Sobel gradient; |-1020| still fits one bit narrower.
    function automatic logic [GRAD_W-2:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        logic [GRAD_W-1:0] neg;
        neg = -g;
        return g[GRAD_W-1] ? neg[GRAD_W-2:0] : g[GRAD_W-2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_gradient_if.sv
`default_nettype none
// ============================================================================
// Module   : sobel_gradient_if
// Brief    : Pixel-in / gradient-out bundle of the Sobel gradient stage.
// Revision : 1.0 - initial release
// ============================================================================
interface sobel_gradient_if;
    import canny_pkg::*;

    logic             enb;
    logic [PIX_W-1:0] In_Pixel;
    logic [7:0]       GradMag;
    logic [1:0]       GradDir;
    logic             out_valid;
    logic             frame_done;

    // Pixel source side
    modport master (
        output enb, In_Pixel,
        input  GradMag, GradDir, out_valid, frame_done
    );

    // Gradient stage side
    modport slave (
        input  enb, In_Pixel,
        output GradMag, GradDir, out_valid, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_buffer
// Brief    : Single-port RAM, asynchronous read of the old contents and
//            synchronous write, giving read-before-write on one address.
// Revision : 1.0 - initial release
// ============================================================================
module line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Write the new column entry; the read above still returns the old one
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end
endmodule
`default_nettype wire

// File: rtl/sobel_gradient.sv
`default_nettype none
// ============================================================================
// Module   : sobel_gradient
// Brief    : Sobel gradient magnitude and quantised direction over a 3x3
//            window built from two line buffers. Fixed 2-cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module sobel_gradient
    import canny_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int MAG_SHIFT  = 3
) (
    input  logic            clk,
    input  logic            reset,
    sobel_gradient_if.slave pix_if
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] C_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] R_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] C_TWO  = CW'(2);
    localparam logic [RW-1:0] R_TWO  = RW'(2);

    logic                                accept;
    logic [CW-1:0]                       c_q, c_d;
    logic [RW-1:0]                       r_q, r_d;
    logic [2*PIX_W-1:0]                  lb_rdata, lb_wdata;
    logic [2:0][2:0][PIX_W-1:0]          win_q;
    logic                                v0_q, done0_q, v1_q, done1_q;
    logic signed [GRAD_W-1:0]            gx_d, gy_d, gx_q, gy_q;
    logic [GRAD_W-2:0]                   ax, ay;
    logic [MAG_W-1:0]                    mag, mag_sh;
    logic [7:0]                          mag_sat, mag_q;
    logic [GRAD_W+2:0]                   ax2, ax5, ay2, ay5;
    grad_dir_t                           dir_d, dir_q;
    logic                                out_valid_q, frame_done_q;

    // Reset wins over a coincident pixel.
    assign accept = pix_if.enb & ~reset;

    // Raster position of the pixel being accepted
    always_comb begin
        c_d = c_q;
        r_d = r_q;
        if (accept) begin
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + RW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    // Register the column/row counters
    always_ff @(posedge clk) begin
        if (reset) begin
            c_q <= '0;
            r_q <= '0;
        end else begin
            c_q <= c_d;
            r_q <= r_d;
        end
    end

    // Lower half holds row r-1, upper half row r-2; old row r-1 ages into r-2.
    assign lb_wdata = {lb_rdata[PIX_W-1:0], pix_if.In_Pixel};

    line_buffer #(
        .DEPTH (IMG_WIDTH),
        .WIDTH (2*PIX_W)
    ) u_line_buffer (
        .clk     (clk),
        .we_i    (accept),
        .addr_i  (c_q),
        .wdata_i (lb_wdata),
        .rdata_o (lb_rdata)
    );

    // Shift a new column into the window and flag interior centres
    always_ff @(posedge clk) begin
        if (reset) begin
            win_q   <= '0;
            v0_q    <= 1'b0;
            done0_q <= 1'b0;
        end else begin
            v0_q    <= accept && (r_q >= R_TWO) && (c_q >= C_TWO);
            done0_q <= accept && (r_q == R_LAST) && (c_q == C_LAST);
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    win_q[i][0] <= win_q[i][1];
                    win_q[i][1] <= win_q[i][2];
                end
                win_q[0][2] <= lb_rdata[2*PIX_W-1:PIX_W];
                win_q[1][2] <= lb_rdata[PIX_W-1:0];
                win_q[2][2] <= pix_if.In_Pixel;
            end
        end
    end

    // Sobel Gx/Gy from the current window
    always_comb begin
        gx_d = $signed({1'b0, wsum(win_q[0][2], win_q[1][2], win_q[2][2])})
             - $signed({1'b0, wsum(win_q[0][0], win_q[1][0], win_q[2][0])});
        gy_d = $signed({1'b0, wsum(win_q[2][0], win_q[2][1], win_q[2][2])})
             - $signed({1'b0, wsum(win_q[0][0], win_q[0][1], win_q[0][2])});
    end

    // Gradient register stage; advances every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            gx_q    <= '0;
            gy_q    <= '0;
            v1_q    <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            gx_q    <= gx_d;
            gy_q    <= gy_d;
            v1_q    <= v0_q;
            done1_q <= done0_q;
        end
    end

    // Scaled/saturated magnitude and direction sector (tan 22.5 ~ 2/5)
    always_comb begin
        ax      = abs_grad(gx_q);
        ay      = abs_grad(gy_q);
        mag     = MAG_W'(ax) + MAG_W'(ay);
        mag_sh  = mag >> MAG_SHIFT;
        mag_sat = (mag_sh > MAG_W'(255)) ? 8'hFF : mag_sh[7:0];
        ax2     = (GRAD_W+3)'({ax, 1'b0});
        ay2     = (GRAD_W+3)'({ay, 1'b0});
        ax5     = (GRAD_W+3)'({ax, 2'b00}) + (GRAD_W+3)'(ax);
        ay5     = (GRAD_W+3)'({ay, 2'b00}) + (GRAD_W+3)'(ay);
        dir_d   = DIR_0;
        if (ay5 <= ax2) begin
            dir_d = DIR_0;
        end else if (ay2 >= ax5) begin
            dir_d = DIR_90;
        end else if (gx_q[GRAD_W-1] == gy_q[GRAD_W-1]) begin
            dir_d = DIR_45;
        end else begin
            dir_d = DIR_135;
        end
    end

    // Output register; results hold while no new centre is valid
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_q        <= '0;
            dir_q        <= DIR_0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_valid_q  <= v1_q;
            frame_done_q <= done1_q;
            if (v1_q) begin
                mag_q <= mag_sat;
                dir_q <= dir_d;
            end
        end
    end

    assign pix_if.GradMag    = mag_q;
    assign pix_if.GradDir    = dir_q;
    assign pix_if.out_valid  = out_valid_q;
    assign pix_if.frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_gradient
// Brief    : Scoreboard bench for sobel_gradient on an 8x8 image. A second
//            instance with MAG_SHIFT=2 sees the same pixel stream.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sobel_gradient;
    localparam int W = 8;
    localparam int H = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sobel_gradient_if ifa ();
    sobel_gradient_if ifb ();

    sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_SHIFT(3)) u_dut (
        .clk    (clk),
        .reset  (reset),
        .pix_if (ifa)
    );

    sobel_gradient #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_SHIFT(2)) u_dut_s2 (
        .clk    (clk),
        .reset  (reset),
        .pix_if (ifb)
    );

    typedef struct {
        int mag3;
        int mag2;
        int dir;
        int done;
        int due;
        int fid;
        int cr;
        int cc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   edge_cnt = 0;
    bit   mon_en = 1'b0;
    int   last_mag = 0;
    int   last_dir = 0;
    int   n_out = 0;
    int   n_done = 0;
    int   cur_fid = 0;
    int   mr = 0;
    int   mc = 0;
    int   img [H][W];
    int   cap_mag [8][H][W];
    int   cap_mag2 [8][H][W];
    int   cap_dir [8][H][W];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (edge %0d)", name, act, expv, edge_cnt);
        end
    endtask

    // Test patterns: 0 const 100, 1 vertical step, 2 horizontal step, 3 corner, 4 const 50
    function automatic int pat(input int kind, input int r, input int c);
        case (kind)
            0: return 100;
            1: return (c >= 4) ? 80 : 0;
            2: return (r >= 4) ? 80 : 0;
            3: return (r >= 4 && c >= 4) ? 255 : 0;
            default: return 50;
        endcase
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mag_ref(input int gx, input int gy, input int sh);
        int m;
        m = (iabs(gx) + iabs(gy)) >> sh;
        return (m > 255) ? 255 : m;
    endfunction

    function automatic int dir_ref(input int gx, input int gy);
        int ax, ay;
        ax = iabs(gx);
        ay = iabs(gy);
        if (5 * ay <= 2 * ax) return 0;
        if (2 * ay >= 5 * ax) return 2;
        if (gx * gy > 0) return 1;
        return 3;
    endfunction

    // Reference model: expected result for every accepted interior pixel
    task automatic model_accept(input int pix);
        exp_t e;
        int   gx, gy, cr, cc;
        img[mr][mc] = pix;
        if (mr >= 2 && mc >= 2) begin
            cr = mr - 1;
            cc = mc - 1;
            gx = (img[cr-1][cc+1] + 2 * img[cr][cc+1] + img[cr+1][cc+1])
               - (img[cr-1][cc-1] + 2 * img[cr][cc-1] + img[cr+1][cc-1]);
            gy = (img[cr+1][cc-1] + 2 * img[cr+1][cc] + img[cr+1][cc+1])
               - (img[cr-1][cc-1] + 2 * img[cr-1][cc] + img[cr-1][cc+1]);
            e.mag3 = mag_ref(gx, gy, 3);
            e.mag2 = mag_ref(gx, gy, 2);
            e.dir  = dir_ref(gx, gy);
            e.done = (mr == H - 1 && mc == W - 1) ? 1 : 0;
            e.due  = edge_cnt + 2;
            e.fid  = cur_fid;
            e.cr   = cr;
            e.cc   = cc;
            q.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    task automatic send(input int pix, input bit en);
        ifa.enb = en;
        ifb.enb = en;
        ifa.In_Pixel = 8'(pix);
        ifb.In_Pixel = 8'(pix);
        @(posedge clk);
        #1;
        if (en && !reset) model_accept(pix);
    endtask

    task automatic send_frame(input int kind, input int fid, input bit stall);
        int k;
        k = 0;
        cur_fid = fid;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (stall && (k % 3 == 2)) send(0, 1'b0);
                send(pat(kind, r, c), 1'b1);
                k++;
            end
        end
    endtask

    task automatic drain();
        repeat (4) send(0, 1'b0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_out_valid"}, ifa.out_valid, 0);
        chk({tag, "_GradMag"}, ifa.GradMag, 0);
        chk({tag, "_GradDir"}, ifa.GradDir, 0);
        chk({tag, "_frame_done"}, ifa.frame_done, 0);
    endtask

    // Monitor: pop and compare whenever the DUT presents a result
    always @(negedge clk) begin
        if (mon_en) begin
            if (ifa.out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out_valid actual 1 expected 0 (edge %0d)", edge_cnt);
                end else begin
                    mon_e = q.pop_front();
                    chk("latency_edge", edge_cnt, mon_e.due);
                    chk("GradMag", ifa.GradMag, mon_e.mag3);
                    chk("GradDir", ifa.GradDir, mon_e.dir);
                    chk("frame_done", ifa.frame_done, mon_e.done);
                    chk("s2_out_valid", ifb.out_valid, 1);
                    chk("s2_GradMag", ifb.GradMag, mon_e.mag2);
                    cap_mag[mon_e.fid][mon_e.cr][mon_e.cc]  = ifa.GradMag;
                    cap_dir[mon_e.fid][mon_e.cr][mon_e.cc]  = ifa.GradDir;
                    cap_mag2[mon_e.fid][mon_e.cr][mon_e.cc] = ifb.GradMag;
                    last_mag = mon_e.mag3;
                    last_dir = mon_e.dir;
                    n_out++;
                    if (ifa.frame_done === 1'b1) n_done++;
                end
            end else begin
                chk("idle_out_valid", ifa.out_valid, 0);
                chk("idle_frame_done", ifa.frame_done, 0);
                chk("hold_GradMag", ifa.GradMag, last_mag);
                chk("hold_GradDir", ifa.GradDir, last_dir);
                if (q.size() > 0 && q[0].due <= edge_cnt) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_output actual none expected centre (%0d,%0d) at edge %0d",
                             q[0].cr, q[0].cc, q[0].due);
                    mon_e = q.pop_front();
                end
            end
        end
    end

    initial begin
        int base_out, base_done, e40;
        for (int f = 0; f < 8; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++) begin
                    cap_mag[f][r][c]  = -1;
                    cap_mag2[f][r][c] = -1;
                    cap_dir[f][r][c]  = -1;
                end
        ifa.enb = 1'b0; ifb.enb = 1'b0;
        ifa.In_Pixel = '0; ifb.In_Pixel = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("reset");
        mon_en = 1'b1;

        // Constant frame: 36 zero outputs, one frame_done
        base_out = n_out; base_done = n_done;
        send_frame(0, 0, 1'b0);
        drain();
        chk("const_out_count", n_out - base_out, 36);
        chk("const_done_count", n_done - base_done, 1);

        // Vertical then horizontal step, back to back
        send_frame(1, 1, 1'b0);
        send_frame(2, 2, 1'b0);
        drain();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                e40 = (c == 3 || c == 4) ? 40 : 0;
                chk("vstep_mag", cap_mag[1][r][c], e40);
                chk("vstep_dir", cap_dir[1][r][c], 0);
                e40 = (r == 3 || r == 4) ? 40 : 0;
                chk("hstep_mag", cap_mag[2][r][c], e40);
                chk("hstep_dir", cap_dir[2][r][c], (e40 != 0) ? 2 : 0);
            end

        // Corner frame: diagonal at (4,4), vertical edge at (4,5), saturation at shift 2
        send_frame(3, 3, 1'b0);
        drain();
        chk("corner44_mag", cap_mag[3][4][4], 191);
        chk("corner44_dir", cap_dir[3][4][4], 1);
        chk("corner44_mag_s2", cap_mag2[3][4][4], 255);
        chk("corner45_mag", cap_mag[3][4][5], 127);
        chk("corner45_dir", cap_dir[3][4][5], 2);

        // Vertical step with enb low every third cycle
        send_frame(1, 4, 1'b1);
        drain();
        for (int r = 1; r < H - 1; r++)
            for (int c = 1; c < W - 1; c++) begin
                chk("stall_mag", cap_mag[4][r][c], (c == 3 || c == 4) ? 40 : 0);
                chk("stall_dir", cap_dir[4][r][c], 0);
            end

        // Mid-frame reset after 20 pixels, reset coinciding with enb=1
        cur_fid = 5;
        for (int i = 0; i < 20; i++) send(pat(1, i / W, i % W), 1'b1);
        reset = 1'b1;
        ifa.enb = 1'b1; ifb.enb = 1'b1;
        ifa.In_Pixel = 8'd77; ifb.In_Pixel = 8'd77;
        @(posedge clk);
        #1;
        q.delete();
        last_mag = 0;
        last_dir = 0;
        mr = 0;
        mc = 0;
        reset = 1'b0;
        ifa.enb = 1'b0; ifb.enb = 1'b0;
        @(negedge clk);
        chk_idle_outputs("midreset");

        base_out = n_out; base_done = n_done;
        send_frame(4, 6, 1'b0);
        drain();
        chk("after_reset_out_count", n_out - base_out, 36);
        chk("after_reset_done_count", n_done - base_done, 1);
        chk("after_reset_mag22", cap_mag[6][1][1], 0);

        chk("scoreboard_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sobel_gradient.md
# sobel_gradient

Gradient stage of the Canny edge-detection pipeline. It sits directly downstream of the smoothing filter and consumes its 8-bit smoothed pixel stream in raster order. It buffers two image lines to form a 3x3 window and applies the Sobel operators. For every interior pixel it emits a scaled gradient magnitude and a 2-bit quantised direction, which the non-maximum-suppression stage consumes.

## Interface
- IMG_WIDTH, 640: pixels per line, ≥3
- IMG_HEIGHT, 480: lines per frame, ≥3
- MAG_SHIFT, 3: right shift applied to |Gx|+|Gy| before 8-bit saturation
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- enb  in  1  input valid; In_Pixel accepted on a rising edge when 1
- In_Pixel  in  8  smoothed pixel, unsigned, raster order
- GradMag  out  8  saturated scaled magnitude
- GradDir  out  2  quantised direction: 0=0°, 1=45°, 2=90°, 3=135°
- out_valid  out  1  GradMag/GradDir valid this cycle
- frame_done  out  1  one-cycle pulse coincident with the last output of a frame

## Operation
- Column counter c (0..W-1) and row counter r (0..H-1) advance only on accepted pixels. c wraps to 0 and increments r; after (H-1,W-1) both wrap to 0.
- Two line buffers hold rows r-1 and r-2, read/written at address c per accepted pixel.
- A 3x3 window shift register w[i][j] is built from those rows. i=0 is row r-2 and i=2 is row r; j=0 is column c-2 and j=2 is column c.
- Gx = (w02+2w12+w22) − (w00+2w10+w20), 11-bit signed, range ±1020.
- Gy = (w20+2w21+w22) − (w00+2w01+w02), 11-bit signed.
- mag = |Gx|+|Gy|, 12 bits unsigned. GradMag = min(mag >> MAG_SHIFT, 255).
- Direction, with ax=|Gx| and ay=|Gy|:
  - 5·ay ≤ 2·ax → 0
  - else 2·ay ≥ 5·ax → 2
  - else Gx·Gy > 0 → 1
  - else → 3
  - Gx=Gy=0 gives 0.
- An output is produced only when the accepted pixel has r≥2 and c≥2. Its result is for centre (r-1,c-1).
  - Each frame therefore yields (H-2)·(W-2) outputs.
  - Borders are never emitted.
  - The window straddling a line wrap (c<2) is discarded.

## Timing
- Pixel accepted at edge t (enb=1) with r≥2 and c≥2 → out_valid=1 with its result during cycle t+2, i.e. after edge t+2.
- The 2-stage output pipeline (window/sum register, then magnitude/direction register) advances every cycle, independent of enb. Latency is fixed at 2 regardless of stalls.
- enb=0 holds counters, line buffers and window; no new outputs are created.
- GradMag/GradDir hold their last value while out_valid=0.
- frame_done=1 in the same cycle as the output for centre (H-2,W-2).
- Back-to-back frames need no gap. Rows 0–1 of the new frame are never emitted, so stale line-buffer contents are harmless.
- Reset, including mid-frame: r, c and window go to 0 and pipeline valids are cleared. GradMag=0, GradDir=0, out_valid=0, frame_done=0 from the cycle after reset is sampled. Line-buffer RAM is not cleared. In-flight results are dropped.
- reset with enb=1 in the same cycle: reset wins and the pixel is dropped.

## Structure
- Package canny_pkg:
  - PIX_W=8
  - GRAD_W=11
  - MAG_W=12
  - direction codes DIR_0, DIR_45, DIR_90, DIR_135
- Sub-module line_buffer (parameters DEPTH, WIDTH): single-port read-before-write RAM with synchronous write on enable. Instantiated twice, or once at double width.
- The top level holds the counters, window, Sobel arithmetic, quantiser and valid pipeline.

## Test plan
All cases use IMG_WIDTH=8, IMG_HEIGHT=8, MAG_SHIFT=3 unless stated.
- Constant frame, all pixels 100, enb held high → exactly 36 out_valid pulses, all GradMag=0, GradDir=0; frame_done once, with the 36th.
- Vertical step, columns 0–3=0 and 4–7=80 → for centres in columns 3 and 4, GradMag=40, GradDir=0. All other centres give 0.
- Horizontal step, rows 0–3=0 and rows 4–7=80 → for centres in rows 3 and 4, GradMag=40, GradDir=2.
- Corner, pixel=255 where r≥4 and c≥4, otherwise 0:
  - centre (4,4): GradMag=191, GradDir=1.
  - rerun with MAG_SHIFT=2: centre (4,4) gives GradMag=255 (saturated).
- Vertical-step frame with enb low every third cycle → output value sequence identical to the gap-free run; each out_valid exactly 2 cycles after its pixel's accept edge.
- Reset after 20 accepted pixels, then a full constant-50 frame → no out_valid before the 19th pixel of the new frame, i.e. (2,2). First out_valid 2 cycles after that pixel; 36 outputs of 0.
